// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: ALUOp/function decode, registered single-cycle ALU
// and an iterative shift-add multiplier with busy/flush handshake.
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 6,
    parameter int MUL_EN = 1,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func_code,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic              flush,
    output logic [3:0]        alu_ctl,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              out_valid,
    output logic              busy,
    output logic              illegal
);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_SLL = 4'b1000;
    localparam logic [3:0] CTL_SRL = 4'b1001;
    localparam logic [3:0] CTL_MUL = 4'b1010;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_ILL = 4'b1111;

    localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(6'd0);
    localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(6'd1);
    localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(6'd2);
    localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(6'd3);
    localparam logic [FUNC_W-1:0] F_SLT = FUNC_W'(6'd4);
    localparam logic [FUNC_W-1:0] F_NOR = FUNC_W'(6'd5);
    localparam logic [FUNC_W-1:0] F_SLL = FUNC_W'(6'd6);
    localparam logic [FUNC_W-1:0] F_SRL = FUNC_W'(6'd7);
    localparam logic [FUNC_W-1:0] F_MUL = FUNC_W'(6'd8);

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t             state_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   acc_q, mcand_q, mplier_q;
    logic [WIDTH-1:0]   acc_d, mcand_d, mplier_d;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q, out_valid_q, busy_q, illegal_q;
    logic [3:0]         alu_ctl_q;
    logic [3:0]         ctl_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic [SHW-1:0]     shamt_s;

    // Decode ALUOp and function field into the 4-bit ALU control code
    always_comb begin
        ctl_s = CTL_ILL;
        case (alu_op)
            2'b00: ctl_s = CTL_ADD;
            2'b01: ctl_s = CTL_SUB;
            2'b11: ctl_s = CTL_OR;
            2'b10: begin
                case (func_code)
                    F_ADD:   ctl_s = CTL_ADD;
                    F_SUB:   ctl_s = CTL_SUB;
                    F_AND:   ctl_s = CTL_AND;
                    F_OR:    ctl_s = CTL_OR;
                    F_SLT:   ctl_s = CTL_SLT;
                    F_NOR:   ctl_s = CTL_NOR;
                    F_SLL:   ctl_s = CTL_SLL;
                    F_SRL:   ctl_s = CTL_SRL;
                    F_MUL: begin
                        if (MUL_EN != 0) ctl_s = CTL_MUL;
                        else             ctl_s = CTL_ILL;
                    end
                    default: ctl_s = CTL_ILL;
                endcase
            end
            default: ctl_s = CTL_ILL;
        endcase
    end

    // Single-cycle ALU datapath; illegal and mul codes yield zero here
    always_comb begin
        shamt_s   = op_a[SHW-1:0];
        alu_res_s = {WIDTH{1'b0}};
        case (ctl_s)
            CTL_ADD: alu_res_s = op_a + op_b;
            CTL_SUB: alu_res_s = op_a - op_b;
            CTL_AND: alu_res_s = op_a & op_b;
            CTL_OR:  alu_res_s = op_a | op_b;
            CTL_NOR: alu_res_s = ~(op_a | op_b);
            CTL_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            CTL_SLL: alu_res_s = op_b << shamt_s;
            CTL_SRL: alu_res_s = op_b >> shamt_s;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One shift-add multiply step: conditional add, then realign operands
    always_comb begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        else             acc_d = acc_q;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {SHW{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            mcand_q     <= {WIDTH{1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
            alu_ctl_q   <= 4'b0000;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && ctl_s == CTL_MUL) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        acc_q    <= {WIDTH{1'b0}};
                        cnt_q    <= {SHW{1'b0}};
                        busy_q   <= 1'b1;
                        state_q  <= S_MUL;
                    end else if (in_valid) begin
                        result_q    <= alu_res_s;
                        zero_q      <= (alu_res_s == {WIDTH{1'b0}});
                        alu_ctl_q   <= ctl_s;
                        illegal_q   <= (ctl_s == CTL_ILL);
                        out_valid_q <= 1'b1;
                    end
                end
                S_MUL: begin
                    // Flush abandons the product; visible outputs keep old values
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_q + {{(SHW-1){1'b0}}, 1'b1};
                        if (cnt_q == CNT_LAST) begin
                            result_q    <= acc_d;
                            zero_q      <= (acc_d == {WIDTH{1'b0}});
                            alu_ctl_q   <= CTL_MUL;
                            illegal_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_ctl   = alu_ctl_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a WIDTH=32 multiply-capable instance and a
// MUL_EN=0 instance sharing the same stimulus.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  alu_op;
    logic [5:0]  func_code;
    logic [31:0] op_a, op_b;
    logic        flush;

    logic [3:0]  alu_ctl, alu_ctl2;
    logic [31:0] result, result2;
    logic        zero, zero2, out_valid, out_valid2, busy, busy2, illegal, illegal2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .FUNC_W(6), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
        .func_code(func_code), .op_a(op_a), .op_b(op_b), .flush(flush),
        .alu_ctl(alu_ctl), .result(result), .zero(zero), .out_valid(out_valid),
        .busy(busy), .illegal(illegal)
    );

    alu_exec_unit #(.WIDTH(32), .FUNC_W(6), .MUL_EN(0)) dut_nomul (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
        .func_code(func_code), .op_a(op_a), .op_b(op_b), .flush(flush),
        .alu_ctl(alu_ctl2), .result(result2), .zero(zero2), .out_valid(out_valid2),
        .busy(busy2), .illegal(illegal2)
    );

    // Present one op for one edge, then sample #1 after that edge
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        alu_op = op; func_code = fn; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++; if (result !== 32'h0) $display("FAIL reset_result got %h exp 0", result); else pass_cnt++;
        total_cnt++; if (zero !== 1'b1) $display("FAIL reset_zero got %b exp 1", zero); else pass_cnt++;
        total_cnt++; if (alu_ctl !== 4'b0000) $display("FAIL reset_ctl got %b exp 0000", alu_ctl); else pass_cnt++;
        total_cnt++; if ({out_valid, busy, illegal} !== 3'b000)
            $display("FAIL reset_flags got %b exp 000", {out_valid, busy, illegal}); else pass_cnt++;
    endtask

    task automatic test_single_cycle();
        issue(2'b10, 6'b000001, 32'd5, 32'd7);
        total_cnt++; if (result !== 32'hFFFF_FFFE) $display("FAIL sub_result got %h exp fffffffe", result); else pass_cnt++;
        total_cnt++; if (alu_ctl !== 4'b0110) $display("FAIL sub_ctl got %b exp 0110", alu_ctl); else pass_cnt++;
        total_cnt++; if ({zero, out_valid, illegal} !== 3'b010)
            $display("FAIL sub_flags got %b exp 010", {zero, out_valid, illegal}); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL ov_pulse got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (result !== 32'hFFFF_FFFE) $display("FAIL result_hold got %h exp fffffffe", result); else pass_cnt++;
        issue(2'b10, 6'b000100, 32'hFFFF_FFFF, 32'd1);
        total_cnt++; if (result !== 32'd1 || alu_ctl !== 4'b0111)
            $display("FAIL slt got %h/%b exp 1/0111", result, alu_ctl); else pass_cnt++;
        issue(2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd1);
        total_cnt++; if (result !== 32'h0 || zero !== 1'b1 || alu_ctl !== 4'b0010)
            $display("FAIL add_wrap got %h/%b/%b exp 0/1/0010", result, zero, alu_ctl); else pass_cnt++;
        issue(2'b01, 6'b000000, 32'd9, 32'd4);
        total_cnt++; if (result !== 32'd5 || alu_ctl !== 4'b0110)
            $display("FAIL aluop01 got %h/%b exp 5/0110", result, alu_ctl); else pass_cnt++;
        issue(2'b11, 6'b000000, 32'h0000_00F0, 32'h0000_000F);
        total_cnt++; if (result !== 32'h0000_00FF || alu_ctl !== 4'b0001)
            $display("FAIL aluop11 got %h/%b exp ff/0001", result, alu_ctl); else pass_cnt++;
    endtask

    task automatic test_shift_logic();
        issue(2'b10, 6'b000110, 32'd4, 32'h0000_000F);
        total_cnt++; if (result !== 32'h0000_00F0 || alu_ctl !== 4'b1000)
            $display("FAIL sll got %h/%b exp f0/1000", result, alu_ctl); else pass_cnt++;
        issue(2'b10, 6'b000111, 32'd31, 32'h8000_0000);
        total_cnt++; if (result !== 32'd1 || alu_ctl !== 4'b1001)
            $display("FAIL srl got %h/%b exp 1/1001", result, alu_ctl); else pass_cnt++;
        issue(2'b10, 6'b000010, 32'h0000_00F0, 32'h0000_003C);
        total_cnt++; if (result !== 32'h0000_0030 || alu_ctl !== 4'b0000)
            $display("FAIL and got %h/%b exp 30/0000", result, alu_ctl); else pass_cnt++;
        issue(2'b10, 6'b000101, 32'd0, 32'd0);
        total_cnt++; if (result !== 32'hFFFF_FFFF || alu_ctl !== 4'b1100)
            $display("FAIL nor got %h/%b exp ffffffff/1100", result, alu_ctl); else pass_cnt++;
    endtask

    task automatic test_reset_mid_mul();
        issue(2'b10, 6'b001000, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL rmm_busy_before got %b exp 1", busy); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if ({busy, out_valid, zero} !== 3'b001)
            $display("FAIL rmm_flags got %b exp 001", {busy, out_valid, zero}); else pass_cnt++;
        total_cnt++; if (result !== 32'h0) $display("FAIL rmm_result got %h exp 0", result); else pass_cnt++;
        #3 reset = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if ({busy, out_valid} !== 2'b00)
            $display("FAIL rmm_after got %b exp 00", {busy, out_valid}); else pass_cnt++;
    endtask

    task automatic test_mul();
        int busy_n = 0, ov_n = 0, ov_at = -1;
        logic [31:0] res_at = 32'h0;
        logic [3:0]  ctl_at = 4'h0;
        issue(2'b10, 6'b001000, 32'h0001_0001, 32'h0000_0003);
        if (busy === 1'b1) busy_n++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mul_accept_ov got %b exp 0", out_valid); else pass_cnt++;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                alu_op = 2'b00; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (busy === 1'b1) busy_n++;
            if (out_valid === 1'b1) begin
                ov_n++; ov_at = i; res_at = result; ctl_at = alu_ctl;
            end
        end
        total_cnt++; if (busy_n != 32) $display("FAIL mul_busy_cycles got %0d exp 32", busy_n); else pass_cnt++;
        total_cnt++; if (ov_n != 1) $display("FAIL mul_ov_count got %0d exp 1", ov_n); else pass_cnt++;
        total_cnt++; if (ov_at != 32) $display("FAIL mul_latency got %0d exp 33", ov_at + 1); else pass_cnt++;
        total_cnt++; if (res_at !== 32'h0003_0003 || ctl_at !== 4'b1010)
            $display("FAIL mul_result got %h/%b exp 00030003/1010", res_at, ctl_at); else pass_cnt++;
    endtask

    task automatic test_mul_wrap();
        int seen = 0;
        issue(2'b10, 6'b001000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        total_cnt++; if (seen != 1 || result !== 32'd1 || zero !== 1'b0)
            $display("FAIL mul_wrap got seen=%0d %h/%b exp 1 1/0", seen, result, zero); else pass_cnt++;
    endtask

    task automatic test_flush();
        int ov_n = 0;
        issue(2'b10, 6'b001000, 32'd100, 32'd200);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total_cnt++; if ({busy, out_valid} !== 2'b00)
            $display("FAIL flush_flags got %b exp 00", {busy, out_valid}); else pass_cnt++;
        total_cnt++; if (result !== 32'd1) $display("FAIL flush_hold got %h exp 1", result); else pass_cnt++;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || busy === 1'b1) ov_n++;
        end
        total_cnt++; if (ov_n != 0) $display("FAIL flush_quiet got %0d exp 0", ov_n); else pass_cnt++;
        issue(2'b00, 6'b000000, 32'd2, 32'd2);
        total_cnt++; if (result !== 32'd4 || out_valid !== 1'b1)
            $display("FAIL flush_add got %h/%b exp 4/1", result, out_valid); else pass_cnt++;
        flush = 1'b1;
        issue(2'b00, 6'b000000, 32'd3, 32'd4);
        flush = 1'b0;
        total_cnt++; if (result !== 32'd7 || out_valid !== 1'b1)
            $display("FAIL idle_flush_add got %h/%b exp 7/1", result, out_valid); else pass_cnt++;
    endtask

    task automatic test_illegal();
        issue(2'b10, 6'b111111, 32'd12, 32'd34);
        total_cnt++; if (alu_ctl !== 4'b1111 || illegal !== 1'b1)
            $display("FAIL ill_ctl got %b/%b exp 1111/1", alu_ctl, illegal); else pass_cnt++;
        total_cnt++; if (result !== 32'h0 || zero !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL ill_res got %h/%b/%b exp 0/1/1", result, zero, out_valid); else pass_cnt++;
        issue(2'b10, 6'b001000, 32'd6, 32'd7);
        total_cnt++; if (alu_ctl2 !== 4'b1111 || illegal2 !== 1'b1 || out_valid2 !== 1'b1 || busy2 !== 1'b0)
            $display("FAIL nomul_ill got %b/%b/%b/%b exp 1111/1/1/0", alu_ctl2, illegal2, out_valid2, busy2); else pass_cnt++;
        total_cnt++; if (result2 !== 32'h0 || zero2 !== 1'b1)
            $display("FAIL nomul_res got %h/%b exp 0/1", result2, zero2); else pass_cnt++;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        alu_op = 2'b10; func_code = 6'b000000; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (result !== 32'd2 || out_valid !== 1'b1 || illegal !== 1'b0)
            $display("FAIL b2b_0 got %h/%b/%b exp 2/1/0", result, out_valid, illegal); else pass_cnt++;
        func_code = 6'b000001; op_a = 32'd10; op_b = 32'd3;
        @(posedge clk); #1;
        total_cnt++; if (result !== 32'd7 || out_valid !== 1'b1)
            $display("FAIL b2b_1 got %h/%b exp 7/1", result, out_valid); else pass_cnt++;
        func_code = 6'b000011; op_a = 32'h0000_0F00; op_b = 32'h0000_000F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++; if (result !== 32'h0000_0F0F || out_valid !== 1'b1)
            $display("FAIL b2b_2 got %h/%b exp f0f/1", result, out_valid); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; func_code = 6'b000000;
        op_a = 32'h0; op_b = 32'h0; flush = 1'b0;
        #1;
        test_reset();
        #12 reset = 1'b0;
        @(posedge clk); #1;
        test_single_cycle();
        test_shift_logic();
        test_reset_mid_mul();
        test_mul();
        test_mul_wrap();
        test_flush();
        test_illegal();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised EX-stage execution block for the MIPS pipeline. It merges ALU-control decode (ALUOp + function code) with a registered ALU datapath, and adds an iterative multi-cycle multiplier. A busy/stall handshake holds the pipeline while a multiply is in progress. Sits between the ID/EX register and the EX/MEM register.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2, >= 8)
FUNC_W, 6, function-code field width
MUL_EN, 1, 1 = multiply supported; 0 = mul function code decodes as illegal
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation presented this cycle
alu_op  input  2  main-control ALUOp
func_code  input  FUNC_W  R-type function field
op_a  input  WIDTH  operand A (shift amount in A[SHW-1:0])
op_b  input  WIDTH  operand B
flush  input  1  synchronous abort of an in-flight multiply
alu_ctl  output  4  registered decoded control of the last accepted op
result  output  WIDTH  registered result
zero  output  1  registered (result == 0)
out_valid  output  1  one-cycle pulse: result/zero/alu_ctl valid
busy  output  1  high while a multiply is iterating; upstream must stall
illegal  output  1  registered, qualifies out_valid: op was undecodable

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, result=0, zero=1, alu_ctl=4'b0000, out_valid=0, busy=0, illegal=0, internal accumulators=0.
- Decode (combinational, internal):
  - ALUOp 00: add (0010).
  - ALUOp 01: sub (0110).
  - ALUOp 11: or (0001).
  - ALUOp 10, by func_code: 000000 add 0010; 000001 sub 0110; 000010 and 0000; 000011 or 0001; 000100 slt 0111; 000101 nor 1100; 000110 sll 1000; 000111 srl 1001; 001000 mul 1010 (only if MUL_EN).
  - Any other func_code: 1111, illegal.
- Arithmetic: add/sub modulo 2^WIDTH, no overflow flag. slt is signed two's-complement, result 1 or 0. sll/srl shift op_b by op_a[SHW-1:0], logical, zero fill. mul returns the low WIDTH bits of the unsigned product.
- State IDLE, in_valid=1 (accepted whenever busy=0):
  - Single-cycle op: at the next edge, result/zero/alu_ctl/illegal update and out_valid=1 for one cycle. Latency 1.
  - Illegal op: result=0, zero=1, alu_ctl=1111, illegal=1, out_valid=1.
  - mul: latch operands, counter=0, go to MUL, busy=1 from that edge. No out_valid.
- State MUL: one shift-add step per edge (test multiplier LSB, add shifted multiplicand, shift).
  - On the WIDTH-th step edge: result = product, out_valid=1, busy=0, return to IDLE.
  - Accept-to-out_valid latency = WIDTH+1 edges. busy is high for exactly WIDTH cycles.
- in_valid while busy=1 is ignored; nothing is queued.
- flush=1 in MUL: return to IDLE at the next edge, busy=0, no out_valid, result holds its previous value. flush in IDLE has no effect; a same-cycle in_valid is still accepted.
- Reset mid-multiply: immediate abort to reset values; no out_valid.
- out_valid is 0 on every cycle other than the one completion cycle. result/zero/alu_ctl/illegal hold their values between completions.
- A new op may be accepted in the same cycle out_valid is high, giving back-to-back single-cycle throughput.

Test Plan:
1. Reset mid-mul: assert reset with busy=1 -> busy=0, result=0, zero=1, out_valid=0 immediately, without waiting for a clock edge.
2. Single-cycle ops (WIDTH=32): ALUOp=10, func=000001, A=5, B=7 -> next cycle result=0xFFFFFFFE, alu_ctl=0110, zero=0, out_valid pulse. Then func=000100, A=0xFFFFFFFF, B=1 -> result=1.
3. Shifts/logic: sll with A=4, B=0x0000000F -> 0x000000F0. srl with A=31, B=0x80000000 -> 1. nor with A=0, B=0 -> 0xFFFFFFFF.
4. Multiply: func=001000, A=0x00010001, B=0x00000003 -> busy high exactly 32 cycles; out_valid 33 edges after accept; result=0x00030003. An in_valid pulse during busy produces no extra out_valid.
5. Flush: start mul, assert flush at step 10 -> busy=0 next cycle, no out_valid, result unchanged. A following add with A=2, B=2 gives result=4 after 1 cycle.
6. Illegal op: ALUOp=10, func=111111 -> alu_ctl=1111, illegal=1, result=0, zero=1, out_valid pulse. With MUL_EN=0, func=001000 behaves the same way.
